// File: rtl/pipe_adder_pkg.sv
// pipe_adder_pkg: shared mode encodings and default geometry for the pipelined CLA adder
package pipe_adder_pkg;
    localparam logic MODE_ADD  = 1'b0;
    localparam logic MODE_SUB  = 1'b1;
    localparam int   DEF_WIDTH = 32;
    localparam int   DEF_SLICE = 8;
endpackage

// File: rtl/pipe_cla_adder_if.sv
// pipe_cla_adder_if: operand/result bus with valid-ready handshakes on both sides
interface pipe_cla_adder_if import pipe_adder_pkg::*; #(parameter int WIDTH = DEF_WIDTH);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             c;
    logic             sub;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] O;
    logic             o;
    logic             ovf;
    logic             zero;
    logic             out_valid;
    logic             out_ready;
    modport master (output A, B, c, sub, in_valid, out_ready,
                    input  in_ready, O, o, ovf, zero, out_valid);
    modport slave  (input  A, B, c, sub, in_valid, out_ready,
                    output in_ready, O, o, ovf, zero, out_valid);
endinterface

// File: rtl/cla_slice.sv
// cla_slice: combinational W-bit carry-lookahead adder slice
module cla_slice import pipe_adder_pkg::*; #(parameter int W = DEF_SLICE) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co,
    output logic         c_msb
);
    logic [W-1:0] p, g;
    logic [W:0]   c;
    logic         run;
    assign p = a ^ b;
    assign g = a & b;
    // each carry is an independent OR of generate terms gated by the propagate run above them
    always_comb begin
        c   = '0;
        run = 1'b1;
        for (int i = 0; i <= W; i++) begin
            run = 1'b1;
            for (int j = i - 1; j >= 0; j--) begin
                c[i] = c[i] | (g[j] & run);
                run  = run & p[j];
            end
            c[i] = c[i] | (ci & run);
        end
    end
    assign s     = p ^ c[W-1:0];
    assign co    = c[W];
    assign c_msb = c[W-1];
endmodule

// File: rtl/pipe_cla_adder.sv
// pipe_cla_adder: valid/ready pipelined adder/subtractor resolving one SLICE per stage
module pipe_cla_adder import pipe_adder_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SLICE = DEF_SLICE
) (
    input logic             clk,
    input logic             rst_n,
    pipe_cla_adder_if.slave bus
);
    localparam int STAGES = WIDTH / SLICE;
    localparam int L      = STAGES - 1;
    if (WIDTH % SLICE != 0) begin : g_bad_width
        $error("pipe_cla_adder: WIDTH must be a multiple of SLICE");
    end
    // x words carry finished sum slices low and untouched A slices high
    logic [WIDTH-1:0] xi [STAGES];
    logic [WIDTH-1:0] yi [STAGES];
    logic [WIDTH-1:0] nx [STAGES];
    logic [WIDTH-1:0] xq [STAGES];
    logic [WIDTH-1:0] yq [STAGES];
    logic [SLICE-1:0] s_c [STAGES];
    logic             cin [STAGES];
    logic             vin [STAGES];
    logic             cq [STAGES];
    logic             vq [STAGES];
    logic             co_c [STAGES];
    logic             cm_c [STAGES];
    logic             stall, ovf_q, zero_q;
    assign stall        = bus.out_valid && !bus.out_ready;
    assign bus.in_ready = !stall;
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign xi[k]  = bus.A;
            assign yi[k]  = (bus.sub == MODE_SUB) ? ~bus.B : bus.B;
            assign cin[k] = (bus.sub == MODE_SUB) ? 1'b1 : bus.c;
            assign vin[k] = bus.in_valid;
        end else begin : g_body
            assign xi[k]  = xq[k-1];
            assign yi[k]  = yq[k-1];
            assign cin[k] = cq[k-1];
            assign vin[k] = vq[k-1];
        end
        cla_slice #(.W(SLICE)) u_slice (
            .a     (xi[k][k*SLICE +: SLICE]),
            .b     (yi[k][k*SLICE +: SLICE]),
            .ci    (cin[k]),
            .s     (s_c[k]),
            .co    (co_c[k]),
            .c_msb (cm_c[k])
        );
        always_comb begin
            nx[k]                   = xi[k];
            nx[k][k*SLICE +: SLICE] = s_c[k];
        end
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                xq[k] <= '0;
                yq[k] <= '0;
                cq[k] <= 1'b0;
                vq[k] <= 1'b0;
            end else if (!stall) begin
                xq[k] <= nx[k];
                yq[k] <= yi[k];
                cq[k] <= co_c[k];
                vq[k] <= vin[k];
            end
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (!stall) begin
            ovf_q  <= co_c[L] ^ cm_c[L];
            zero_q <= nx[L] == '0;
        end
    end
    assign bus.O         = xq[L];
    assign bus.o         = cq[L];
    assign bus.out_valid = vq[L];
    assign bus.ovf       = ovf_q;
    assign bus.zero      = zero_q;
endmodule

// File: tb/tb_pipe_cla_adder.sv
// tb_pipe_cla_adder: vector table, stall/reset sequences and random stream vs arithmetic model
module tb_pipe_cla_adder;
    localparam int W  = 32;
    localparam int S  = 8;
    localparam int ST = W / S;

    typedef struct packed {
        logic [31:0] O;
        logic        o;
        logic        ovf;
        logic        zero;
    } res_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        c;
        logic        sub;
        res_t        r;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    pipe_cla_adder_if #(.WIDTH(W)) bus ();
    pipe_cla_adder #(.WIDTH(W), .SLICE(S)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int   errors = 0;
    int   checks = 0;
    int   nout = 0;
    res_t sb[$];
    vec_t tv[9];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // true signed/unsigned arithmetic, independent of any carry chain
    function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic c, input logic sub);
        longint sa = longint'($signed(a));
        longint sbv = longint'($signed(b));
        longint hi = (longint'(1) << 31) - 1;
        longint lo = -(longint'(1) << 31);
        longint r;
        logic [32:0] u;
        res_t e;
        r      = sub ? sa - sbv : sa + sbv + longint'(c);
        u      = {1'b0, a} + {1'b0, b} + {32'd0, c};
        e.O    = r[31:0];
        e.ovf  = r > hi || r < lo;
        e.o    = sub ? (a >= b) : u[32];
        e.zero = e.O == 32'd0;
        return e;
    endfunction

    function automatic logic [31:0] rnd_word();
        int unsigned k = $urandom_range(0, 5);
        return k == 0 ? 32'h0 : k == 1 ? 32'hFFFFFFFF : k == 2 ? 32'h7FFFFFFF :
               k == 3 ? 32'h80000000 : 32'($urandom);
    endfunction

    task automatic drive_rand();
        bus.A   = rnd_word();
        bus.B   = rnd_word();
        bus.c   = 1'($urandom_range(0, 1));
        bus.sub = 1'($urandom_range(0, 1));
    endtask

    // sample handshakes mid-cycle, score results, then advance to just after the next edge
    task automatic tick(output bit fired);
        res_t e;
        @(negedge clk);
        fired = bus.in_valid && bus.in_ready;
        if (bus.out_valid && bus.out_ready) begin
            nout++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL stray_result: got %h expected no result", bus.O);
            end else begin
                e = sb.pop_front();
                check("stream_result", {bus.O, bus.o, bus.ovf, bus.zero}, e);
            end
        end
        if (fired) sb.push_back(model(bus.A, bus.B, bus.c, bus.sub));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit   f;
        int   lat, sent, acc, n0, outs;
        logic [31:0] held;
        tv = '{
            '{32'h000000FF, 32'h00000001, 1'b0, 1'b0, '{32'h00000100, 1'b0, 1'b0, 1'b0}},
            '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, '{32'h80000000, 1'b0, 1'b1, 1'b0}},
            '{32'h00000005, 32'h00000005, 1'b0, 1'b1, '{32'h00000000, 1'b1, 1'b0, 1'b1}},
            '{32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, '{32'h00000000, 1'b1, 1'b0, 1'b1}},
            '{32'h00000000, 32'h00000001, 1'b0, 1'b1, '{32'hFFFFFFFF, 1'b0, 1'b0, 1'b0}},
            '{32'h80000000, 32'h00000001, 1'b0, 1'b1, '{32'h7FFFFFFF, 1'b1, 1'b1, 1'b0}},
            '{32'h0000000A, 32'h00000003, 1'b1, 1'b1, '{32'h00000007, 1'b1, 1'b0, 1'b0}},
            '{32'h80000000, 32'h80000000, 1'b0, 1'b0, '{32'h00000000, 1'b1, 1'b1, 1'b1}},
            '{32'h12345678, 32'h87654321, 1'b1, 1'b0, '{32'h9999999A, 1'b0, 1'b0, 1'b0}}
        };
        bus.A = '0; bus.B = '0; bus.c = 1'b0; bus.sub = 1'b0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        #2 rst_n = 1'b0;
        #20;
        check("reset_out_valid", bus.out_valid, 1'b0);
        check("reset_in_ready", bus.in_ready, 1'b1);
        check("reset_result", {bus.O, bus.o, bus.ovf, bus.zero}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (tv[i]) begin
            bus.A = tv[i].a; bus.B = tv[i].b; bus.c = tv[i].c; bus.sub = tv[i].sub;
            bus.in_valid = 1'b1;
            @(negedge clk);
            check($sformatf("tv%0d_in_ready", i), bus.in_ready, 1'b1);
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
            lat = 0;
            while (!bus.out_valid && lat < 10) begin
                @(posedge clk);
                #1;
                lat++;
            end
            check($sformatf("tv%0d_latency", i), lat, ST - 1);
            check($sformatf("tv%0d_result", i), {bus.O, bus.o, bus.ovf, bus.zero}, tv[i].r);
            @(posedge clk);
            #1;
            check($sformatf("tv%0d_single_pulse", i), bus.out_valid, 1'b0);
        end

        // back-pressure: six back-to-back operands against a stalled consumer
        bus.out_ready = 1'b0;
        sent = 0;
        n0 = nout;
        bus.A = 32'h11111111; bus.B = 32'h1; bus.c = 1'b0; bus.sub = 1'b0;
        bus.in_valid = 1'b1;
        repeat (8) begin
            tick(f);
            if (f) begin
                sent++;
                bus.A = 32'h11111111 * (sent + 1); bus.B = sent + 1; bus.sub = sent[0];
            end
        end
        check("stall_accepted", sent, ST);
        check("stall_in_ready", bus.in_ready, 1'b0);
        check("stall_out_valid", bus.out_valid, 1'b1);
        held = bus.O;
        tick(f);
        check("stall_hold", bus.O, held);
        bus.out_ready = 1'b1;
        for (int t = 0; t < 40 && (sent < 6 || sb.size() > 0); t++) begin
            tick(f);
            if (f) begin
                sent++;
                if (sent == 6) bus.in_valid = 1'b0;
                else begin
                    bus.A = 32'h11111111 * (sent + 1); bus.B = sent + 1; bus.sub = sent[0];
                end
            end
        end
        check("stall_drained", nout - n0, 6);
        check("stall_queue_empty", sb.size(), 0);

        // reset with three transactions in flight
        sent = 0;
        drive_rand();
        bus.in_valid = 1'b1;
        for (int t = 0; t < 10 && sent < 3; t++) begin
            tick(f);
            if (f) begin
                sent++;
                drive_rand();
            end
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        tick(f);
        check("pre_reset_out_valid", bus.out_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_out_valid", bus.out_valid, 1'b0);
        check("async_reset_in_ready", bus.in_ready, 1'b1);
        check("async_reset_result", {bus.O, bus.o, bus.ovf, bus.zero}, '0);
        sb.delete();
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        n0 = nout;
        repeat (8) tick(f);
        check("reset_no_stale", nout - n0, 0);

        // random stream with random back-pressure
        n0 = nout;
        acc = 0;
        drive_rand();
        bus.in_valid = 1'($urandom_range(0, 9) < 7);
        bus.out_ready = 1'($urandom_range(0, 9) < 7);
        repeat (600) begin
            tick(f);
            if (f) acc++;
            drive_rand();
            bus.in_valid = 1'($urandom_range(0, 9) < 7);
            bus.out_ready = 1'($urandom_range(0, 9) < 7);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        for (int t = 0; t < 20 && sb.size() > 0; t++) tick(f);
        check("rand_drained", sb.size(), 0);
        check("rand_count", nout - n0, acc);

        // full-rate throughput from an empty pipeline
        acc = 0;
        n0 = nout;
        bus.in_valid = 1'b1;
        drive_rand();
        repeat (20) begin
            tick(f);
            if (f) acc++;
            drive_rand();
        end
        outs = nout - n0;
        check("tput_accepts", acc, 20);
        check("tput_results", outs, 20 - ST);
        bus.in_valid = 1'b0;
        for (int t = 0; t < 20 && sb.size() > 0; t++) tick(f);
        check("tput_drained", nout - n0, 20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
